pipe_lsu: RTL

//  Load/store stage between pipe_exu and pipe_wb. Accepts one EX result per handshake.

---
 rtl/pipe_lsu.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pipe_lsu.sv
// pipe_lsu: load/store stage between EX and WB with a req/gnt/rvalid data-memory port
module pipe_lsu #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 256
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ex_valid_i,
  output logic            lsu_ready_o,
  input  logic            ex_is_load_i,
  input  logic            ex_is_store_i,
  input  logic [1:0]      ex_size_i,
  input  logic            ex_unsigned_i,
  input  logic [XLEN-1:0] ex_addr_i,
  input  logic [XLEN-1:0] ex_wdata_i,
  input  logic [4:0]      ex_rd_i,
  input  logic            ex_rd_wen_i,
  output logic            lsu_valid_o,
  input  logic            wb_ready_i,
  output logic [4:0]      lsu_rd_o,
  output logic [XLEN-1:0] lsu_rd_wdata_o,
  output logic            lsu_rd_wen_o,
  output logic [1:0]      lsu_err_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  output logic [3:0]      dmem_wstrb_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0] rd_q, rd_d;
  logic [1:0] size_q, size_d, off_q, off_d, err_q, err_d;
  logic uns_q, uns_d, wen_q, wen_d, we_q, we_d, res_wen_q, res_wen_d;
  logic [XLEN-3:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d, res_q, res_d, ld_data;
  logic [3:0] wstrb_q, wstrb_d;
  logic accept, is_mem, mis, tout;

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] w, input logic [1:0] sz,
                                             input logic [1:0] off, input logic u);
    logic [XLEN-1:0] s;
    s = w >> {off, 3'b000};
    return sz == 2'd0 ? {{(XLEN-8){~u & s[7]}}, s[7:0]} :
           sz == 2'd1 ? {{(XLEN-16){~u & s[15]}}, s[15:0]} : s;
  endfunction

  assign lsu_ready_o = ~rst_i & (state_q == IDLE | (state_q == RESP & wb_ready_i));
  assign accept = ex_valid_i & lsu_ready_o;
  assign is_mem = ex_is_load_i | ex_is_store_i;
  assign mis = ex_size_i == 2'd3 | (ex_size_i == 2'd1 & ex_addr_i[0]) | (ex_size_i == 2'd2 & |ex_addr_i[1:0]);
  assign tout = cnt_q + CW'(1) == CW'(TIMEOUT);
  assign ld_data = extend(dmem_rdata_i, size_q, off_q, uns_q);

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rd_d = rd_q;
    size_d = size_q;
    off_d = off_q;
    uns_d = uns_q;
    wen_d = wen_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    res_d = res_q;
    res_wen_d = res_wen_q;
    err_d = err_q;
    if (state_q == RESP && wb_ready_i) state_d = IDLE;
    if (accept) begin
      rd_d = ex_rd_i;
      size_d = ex_size_i;
      off_d = ex_addr_i[1:0];
      uns_d = ex_unsigned_i;
      wen_d = ex_rd_wen_i;
      res_d = is_mem ? '0 : ex_addr_i;
      res_wen_d = ~is_mem & ex_rd_wen_i;
      err_d = {1'b0, is_mem & mis};
      state_d = is_mem & ~mis ? REQ : RESP;
      cnt_d = '0;
      if (is_mem & ~mis) begin
        we_d = ex_is_store_i;
        addr_d = ex_addr_i[XLEN-1:2];
        wdata_d = ex_size_i == 2'd0 ? {4{ex_wdata_i[7:0]}} :
                  ex_size_i == 2'd1 ? {2{ex_wdata_i[15:0]}} : ex_wdata_i;
        wstrb_d = ex_is_store_i ? ((ex_size_i == 2'd0 ? 4'b0001 : ex_size_i == 2'd1 ? 4'b0011 : 4'b1111)
                  << ex_addr_i[1:0]) : 4'b0000;
      end
    end
    if (state_q == REQ || state_q == WAIT) begin
      cnt_d = cnt_q + CW'(1);
      // a response arriving on the last allowed cycle wins over the timeout
      if (state_q == REQ && dmem_gnt_i && we_q) state_d = RESP;
      else if ((state_q == WAIT || dmem_gnt_i) && dmem_rvalid_i) begin
        state_d = RESP;
        res_d = ld_data;
        res_wen_d = wen_q;
      end else if (state_q == REQ && dmem_gnt_i) state_d = WAIT;
      else if (tout) begin
        state_d = RESP;
        err_d = 2'd2;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rd_q <= '0;
      size_q <= '0;
      off_q <= '0;
      uns_q <= 1'b0;
      wen_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      res_q <= '0;
      res_wen_q <= 1'b0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rd_q <= rd_d;
      size_q <= size_d;
      off_q <= off_d;
      uns_q <= uns_d;
      wen_q <= wen_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      res_q <= res_d;
      res_wen_q <= res_wen_d;
      err_q <= err_d;
    end
  end

  assign lsu_valid_o = state_q == RESP;
  assign lsu_rd_o = rd_q;
  assign lsu_rd_wdata_o = res_q;
  assign lsu_rd_wen_o = res_wen_q;
  assign lsu_err_o = err_q;
  assign dmem_req_o = state_q == REQ;
  assign dmem_we_o = we_q;
  assign dmem_addr_o = {addr_q, 2'b00};
  assign dmem_wdata_o = wdata_q;
  assign dmem_wstrb_o = wstrb_q;
endmodule
